key_generator: RTL and testbench

KEY_GENERATOR -- requirements
Module: key_generator

---
 rtl/key_gen_pkg.sv | 32 +++
 rtl/key_expand_round.sv | 32 +++
 rtl/key_generator.sv | 103 ++++++++++
 tb/tb_key_generator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_gen_pkg.sv
// Shared types, constants and S-box helpers for the AES-128 key schedule (round keys 0..4).
// The optional stall mode is selected with the KEY_GEN_STALL_EN macro in key_generator.sv.
package key_gen_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] round_key_t;
  typedef logic [127:0] sbox_t [16];

  localparam int NUM_ROUND_KEYS = 5;

  localparam logic [7:0] RCON [NUM_ROUND_KEYS-1] = '{8'h01, 8'h02, 8'h04, 8'h08};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Row holds sixteen entries, lowest nibble in the most significant byte.
  function automatic logic [7:0] sub_byte(input sbox_t tbl, input logic [7:0] b);
    logic [127:0] row;
    logic [6:0]   msb;
    row = tbl[b[7:4]];
    msb = 7'd127 - {b[3:0], 3'b000};
    return row[msb -: 8];
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_expand_round.sv
// Combinational single AES-128 key-schedule round: previous round key in, next round key out.
module key_expand_round
  import key_gen_pkg::*;
(
  input  round_key_t prev_key,
  input  logic [7:0] rcon,
  input  sbox_t      sub_table,
  output round_key_t next_key
);

  word_t w0, w1, w2, w3;
  word_t rot, temp;
  word_t n0, n1, n2, n3;

  always_comb begin
    w0   = prev_key[127:96];
    w1   = prev_key[95:64];
    w2   = prev_key[63:32];
    w3   = prev_key[31:0];
    rot  = rot_word(w3);
    temp = {sub_byte(sub_table, rot[31:24]),
            sub_byte(sub_table, rot[23:16]),
            sub_byte(sub_table, rot[15:8]),
            sub_byte(sub_table, rot[7:0])} ^ {rcon, 24'h000000};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/key_generator.sv
// Sequential AES-128 key expansion producing round keys 0..4, one per clock.
// Define KEY_GEN_STALL_EN to advance only while substitution_table_valid is high.
module key_generator
  import key_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  round_key_t key_initial,
  input  sbox_t      sub_table,
  input  logic       substitution_table_valid,
  output round_key_t key_for_round_0,
  output round_key_t key_for_round_1,
  output round_key_t key_for_round_2,
  output round_key_t key_for_round_3,
  output round_key_t key_for_round_4,
  output logic       key_for_round_0_valid,
  output logic       key_for_round_1_valid,
  output logic       key_for_round_2_valid,
  output logic       key_for_round_3_valid,
  output logic       key_for_round_4_valid
);

  state_e                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  round_key_t                key_q [NUM_ROUND_KEYS];
  round_key_t                key_d [NUM_ROUND_KEYS];
  logic [NUM_ROUND_KEYS-1:0] vld_q, vld_d;
  logic [2:0]                prev_idx;
  logic [7:0]                rcon;
  round_key_t                next_key;
  logic                      adv;

`ifdef KEY_GEN_STALL_EN
  assign adv = substitution_table_valid;
`else
  logic unused_table_valid;
  assign unused_table_valid = substitution_table_valid;
  assign adv = 1'b1;
`endif

  // cnt_q selects the key being produced; its predecessor feeds the round logic.
  always_comb begin
    prev_idx = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
    rcon     = RCON[prev_idx[1:0]];
  end

  key_expand_round u_round (
    .prev_key  (key_q[prev_idx]),
    .rcon      (rcon),
    .sub_table (sub_table),
    .next_key  (next_key)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    vld_d   = vld_q;
    if (adv) begin
      case (state_q)
        IDLE: begin
          key_d[0] = key_initial;
          vld_d[0] = 1'b1;
          cnt_d    = 3'd1;
          state_d  = EXPAND;
        end
        EXPAND: begin
          key_d[cnt_q] = next_key;
          vld_d[cnt_q] = 1'b1;
          cnt_d        = cnt_q + 3'd1;
          if (cnt_q == 3'(NUM_ROUND_KEYS - 1)) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= '0;
      key_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      key_q   <= key_d;
    end
  end

  assign key_for_round_0       = key_q[0];
  assign key_for_round_1       = key_q[1];
  assign key_for_round_2       = key_q[2];
  assign key_for_round_3       = key_q[3];
  assign key_for_round_4       = key_q[4];
  assign key_for_round_0_valid = vld_q[0];
  assign key_for_round_1_valid = vld_q[1];
  assign key_for_round_2_valid = vld_q[2];
  assign key_for_round_3_valid = vld_q[3];
  assign key_for_round_4_valid = vld_q[4];

endmodule

// File: tb/tb_key_generator.sv
// Directed self-checking bench for key_generator using FIPS-197 and hand-checked key vectors.
module tb_key_generator;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_initial;
  logic [127:0] sub_table [16];
  logic         stv;
  logic [127:0] k0, k1, k2, k3, k4;
  logic         v0, v1, v2, v3, v4;
  logic [127:0] rk [5];
  logic [4:0]   vld;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] KEY_A  = 128'h8754AA13_0012E231_88567534_B3A27524;
  localparam logic [127:0] KEY_A1 = 128'hBCC99C7E_BCDB7E4F_348D0B7B_872F7E5F;
  localparam logic [127:0] FIPS_K = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
  localparam logic [127:0] FIPS_R [5] = '{
    128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C,
    128'hA0FAFE17_88542CB1_23A33939_2A6C7605,
    128'hF2C295F2_7A96B943_5935807A_7359F67F,
    128'h3D80477D_4716FE3E_1E237E44_6D7A883B,
    128'hEF44A541_A8525B7F_B671253B_DB0BAD00};

  always #5 clk = ~clk;

  key_generator dut (
    .clk                      (clk),
    .rst                      (rst),
    .key_initial              (key_initial),
    .sub_table                (sub_table),
    .substitution_table_valid (stv),
    .key_for_round_0          (k0),
    .key_for_round_1          (k1),
    .key_for_round_2          (k2),
    .key_for_round_3          (k3),
    .key_for_round_4          (k4),
    .key_for_round_0_valid    (v0),
    .key_for_round_1_valid    (v1),
    .key_for_round_2_valid    (v2),
    .key_for_round_3_valid    (v3),
    .key_for_round_4_valid    (v4)
  );

  assign rk[0] = k0;
  assign rk[1] = k1;
  assign rk[2] = k2;
  assign rk[3] = k3;
  assign rk[4] = k4;
  assign vld   = {v4, v3, v2, v1, v0};

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    row = sub_table[b[7:4]];
    return row[127 - 8*int'(b[3:0]) -: 8];
  endfunction

  // Word-level reference expansion of the full w0..w19 schedule.
  function automatic logic [127:0] model_rk(input logic [127:0] k, input int n);
    logic [31:0] w [20];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 20; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        rc = 8'h01 << (i/4 - 1);
        t  = {t[23:0], t[31:24]};
        t  = {sb(t[31:24]) ^ rc, sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [4:0] mask(input int k);
    return 5'((1 << (k + 1)) - 1);
  endfunction

  task automatic restart(input logic [127:0] key);
    @(negedge clk);
    rst = 1'b1;
    key_initial = key;
    stv = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (vld !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_valids: got %b expected 00000", vld);
    end
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (rk[j] !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_key%0d: got %h expected 0", j, rk[j]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_known_key();
    logic [127:0] exp;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp = (k == 0) ? KEY_A : (k == 1) ? KEY_A1 : model_rk(KEY_A, k);
      n_checks++;
      if (vld !== mask(k)) begin
        n_fail++;
        $display("FAIL known_valid_r%0d: got %b expected %b", k, vld, mask(k));
      end
      n_checks++;
      if (rk[k] !== exp) begin
        n_fail++;
        $display("FAIL known_key_r%0d: got %h expected %h", k, rk[k], exp);
      end
    end
  endtask

  task automatic test_fips();
    restart(FIPS_K);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (vld !== mask(k) || rk[k] !== FIPS_R[k]) begin
        n_fail++;
        $display("FAIL fips_r%0d: got %b/%h expected %b/%h", k, vld, rk[k], mask(k), FIPS_R[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    restart(KEY_A);
    repeat (3) @(negedge clk);
    n_checks++;
    if (vld !== 5'b00111) begin
      n_fail++;
      $display("FAIL midrst_pre: got %b expected 00111", vld);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (vld !== 5'b00000 || k0 !== '0 || k1 !== '0 || k2 !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear: got %b %h %h %h expected zeros", vld, k0, k1, k2);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (vld !== mask(k) || rk[k] !== model_rk(KEY_A, k)) begin
        n_fail++;
        $display("FAIL midrst_regen_r%0d: got %b/%h expected %b/%h", k, vld, rk[k],
                 mask(k), model_rk(KEY_A, k));
      end
    end
  endtask

  task automatic test_key_change_and_hold();
    restart(KEY_A);
    repeat (2) @(negedge clk);
    key_initial = 128'h0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (rk[k] !== model_rk(KEY_A, k)) begin
        n_fail++;
        $display("FAIL keychg_r%0d: got %h expected %h", k, rk[k], model_rk(KEY_A, k));
      end
    end
    repeat (20) begin
      @(negedge clk);
      n_checks++;
      if (vld !== 5'b11111 || k0 !== KEY_A || k4 !== model_rk(KEY_A, 4)) begin
        n_fail++;
        $display("FAIL hold: got %b %h %h expected 11111 %h %h", vld, k0, k4, KEY_A,
                 model_rk(KEY_A, 4));
      end
    end
  endtask

  task automatic test_stall();
    logic [4:0] exp_v [8];
`ifdef KEY_GEN_STALL_EN
    exp_v = '{5'h01, 5'h03, 5'h03, 5'h03, 5'h03, 5'h07, 5'h0F, 5'h1F};
`else
    exp_v = '{5'h01, 5'h03, 5'h07, 5'h0F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
`endif
    restart(FIPS_K);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (vld !== exp_v[c]) begin
        n_fail++;
        $display("FAIL stall_valid_c%0d: got %b expected %b", c, vld, exp_v[c]);
      end
      if (c == 1) stv = 1'b0;
      if (c == 4) stv = 1'b1;
    end
    n_checks++;
    if (k4 !== FIPS_R[4] || k2 !== FIPS_R[2]) begin
      n_fail++;
      $display("FAIL stall_keys: got %h %h expected %h %h", k2, k4, FIPS_R[2], FIPS_R[4]);
    end
  endtask

  initial begin
    sub_table = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    rst         = 1'b1;
    stv         = 1'b1;
    key_initial = KEY_A;
    test_reset();
    test_known_key();
    test_fips();
    test_mid_reset();
    test_key_change_and_hold();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
